// File: rtl/mem_arbiter.sv
// Two-way line-port arbiter: icache vs dcache onto one pmem port, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN alternates contended grants; otherwise dcache has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_req;
  logic              grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_d set means the next contended grant goes to the dcache.
  logic ptr_d;
  assign grant_d = d_req & (~i_read | ptr_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_d      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_read | d_req) begin
            state      <= grant_d ? SERVE_D : SERVE_I;
            addr_q     <= grant_d ? d_addr : i_addr;
            wdata_q    <= grant_d ? d_wdata : '0;
            // A dcache write wins over a simultaneous (illegal) dcache read.
            pmem_write <= grant_d & d_write;
            pmem_read  <= ~(grant_d & d_write);
`ifdef ARB_ROUND_ROBIN_EN
            if (i_read & d_req) ptr_d <= ~ptr_d;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;
  assign i_resp     = (state == SERVE_I) & pmem_resp;
  assign d_resp     = (state == SERVE_D) & pmem_resp;
  assign arb_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized caches and memory, checked every
// cycle against a transaction-level model. Honours ARB_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic [1:0]        arb_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: one outstanding transaction (who, where, what) or none.
  logic              m_busy, m_side_d, m_write, m_next_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic              m_ireq, m_dreq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_side_d = 1'b0; m_write = 1'b0; m_next_d = 1'b0;
      m_addr = '0; m_wdata = '0;
    end else if (!m_busy) begin
      m_ireq = i_read;
      m_dreq = d_read | d_write;
      if (m_ireq || m_dreq) begin
        if (m_ireq && m_dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
          m_side_d = m_next_d;
          m_next_d = !m_next_d;
`else
          m_side_d = 1'b1;
`endif
        end else begin
          m_side_d = m_dreq;
        end
        m_busy  = 1'b1;
        m_write = m_side_d && d_write;
        m_addr  = m_side_d ? d_addr : i_addr;
        m_wdata = m_side_d ? d_wdata : '0;
      end
    end else if (pmem_resp) begin
      m_busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic i_seen = 1'b0, d_seen = 1'b0;
  int   i_done = 0, d_done = 0, i_issued = 0, d_issued = 0;
  int   resp_log[$];
  logic checked = 1'b0;

  task automatic model_check();
    if (!rst_n) return;
    chk("pmem_read",  pmem_read,  m_busy && !m_write);
    chk("pmem_write", pmem_write, m_busy && m_write);
    chk("i_resp", i_resp, m_busy && !m_side_d && pmem_resp);
    chk("d_resp", d_resp, m_busy && m_side_d && pmem_resp);
    chk("i_rdata", i_rdata, pmem_rdata);
    chk("d_rdata", d_rdata, pmem_rdata);
    chk("idle_state", arb_state == 2'd0, !m_busy);
    if (m_busy) chk("pmem_addr", pmem_addr, m_addr);
    if (m_busy && m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
    i_seen = i_resp;
    d_seen = d_resp;
    if (i_resp) begin i_done++; resp_log.push_back(0); end
    if (d_resp) begin d_done++; resp_log.push_back(1); end
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
    checked = 1'b1;
  endtask

  task automatic next();
    if (!checked) begin
      @(negedge clk);
      model_check();
    end
    checked = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_line(output logic [LINE_W-1:0] v);
    for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
  endtask

  // Waits for a strobe, answers it two cycles later, reports who got the response.
  task automatic serve_one(output int side);
    int k;
    logic [LINE_W-1:0] v;
    side = 2;
    k = 0;
    half();
    while (!(pmem_read || pmem_write) && k < 20) begin
      next(); half(); k++;
    end
    if (k >= 20) chk("strobe_timeout", 1'b1, 1'b0);
    next(); next();
    rand_line(v);
    pmem_resp = 1'b1; pmem_rdata = v;
    half();
    side = i_resp ? 0 : (d_resp ? 1 : 2);
    next();
    pmem_resp = 1'b0;
    if (side == 0) i_read = 1'b0;
    if (side == 1) d_read = 1'b0;
  endtask

  int exp_order[6];
  int side;
  int wait_cnt;
  int op;
  logic [LINE_W-1:0] line_v;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 1;
    exp_order[3] = 0; exp_order[4] = 0; exp_order[5] = 1;
`else
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1;
    exp_order[3] = 0; exp_order[4] = 1; exp_order[5] = 0;
`endif
    #23 rst_n = 1'b1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_addr", pmem_addr, '0);
    chk("rst_state", arb_state, 2'd0);
    next();

    // Lone icache miss: strobe cycles 1..5, response in cycle 5.
    i_read = 1'b1; i_addr = 32'h0000_0060;
    half();
    chk("icache_no_strobe_yet", pmem_read, 1'b0);
    next(); half();
    chk("icache_strobe_c1", pmem_read, 1'b1);
    chk("icache_addr_c1", pmem_addr, 32'h60);
    next(); next(); next(); next();
    pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
    half();
    chk("icache_resp_c5", i_resp, 1'b1);
    chk("icache_no_dresp", d_resp, 1'b0);
    chk("icache_rdata", i_rdata, {32{8'hA5}});
    next();
    pmem_resp = 1'b0; i_read = 1'b0;
    half();
    chk("icache_idle_gap", pmem_read, 1'b0);
    next();

    // Dcache write-back; address changes during service are ignored.
    d_write = 1'b1; d_addr = 32'h100; d_wdata = {16{16'h1234}};
    next(); half();
    chk("wb_strobe", pmem_write, 1'b1);
    chk("wb_addr", pmem_addr, 32'h100);
    next();
    d_addr = 32'h200; d_wdata = '1;
    half();
    chk("wb_addr_held", pmem_addr, 32'h100);
    chk("wb_wdata_held", pmem_wdata, {16{16'h1234}});
    next();
    pmem_resp = 1'b1;
    half();
    chk("wb_dresp", d_resp, 1'b1);
    next();
    pmem_resp = 1'b0; d_write = 1'b0;
    next();

    // Illegal read+write: write wins. Then a stray response while idle.
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h140;
    next(); half();
    chk("illegal_write", pmem_write, 1'b1);
    chk("illegal_no_read", pmem_read, 1'b0);
    next();
    pmem_resp = 1'b1;
    next();
    pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    next();
    pmem_resp = 1'b1;
    half();
    chk("stray_no_iresp", i_resp, 1'b0);
    chk("stray_no_dresp", d_resp, 1'b0);
    next();
    pmem_resp = 1'b0;
    next();

    // Three back-to-back contended pairs.
    for (int p = 0; p < 3; p++) begin
      i_read = 1'b1; i_addr = 32'h1000 + 32'(p * 32);
      d_read = 1'b1; d_addr = 32'h2000 + 32'(p * 32);
      serve_one(side);
      chk("contend_order", 32'(side), 32'(exp_order[2*p]));
      serve_one(side);
      chk("contend_order", 32'(side), 32'(exp_order[2*p+1]));
    end
    next();

    // Reset in the middle of a dcache write.
    d_write = 1'b1; d_addr = 32'h180; rand_line(line_v); d_wdata = line_v;
    next(); half();
    chk("pre_reset_write", pmem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("reset_drops_write", pmem_write, 1'b0);
    d_write = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    checked = 1'b1;
    next(); half();
    chk("post_reset_idle", arb_state, 2'd0);
    chk("post_reset_no_dresp", d_resp, 1'b0);
    chk("post_reset_addr", pmem_addr, '0);
    next();

    // Randomized caches and memory.
    i_done = 0; d_done = 0; wait_cnt = 0;
    for (int c = 0; c < 2300; c++) begin
      next();
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (wait_cnt == 0) begin
          pmem_resp = 1'b1; rand_line(line_v); pmem_rdata = line_v;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        pmem_resp = 1'b1; rand_line(line_v); pmem_rdata = line_v;
      end
      if (i_read && i_seen) i_read = 1'b0;
      else if (!i_read && c < 2000 && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_addr = $urandom; i_issued++;
      end else if (i_read) i_addr = $urandom;
      if ((d_read || d_write) && d_seen) begin
        d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write) && c < 2000 && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 8);
        d_read = (op < 5) || (op == 8);
        d_write = (op >= 5);
        d_addr = $urandom; rand_line(line_v); d_wdata = line_v; d_issued++;
      end else if (d_read || d_write) begin
        d_addr = $urandom; rand_line(line_v); d_wdata = line_v;
      end
    end
    chk("drain_done", i_read || d_read || d_write, 1'b0);
    chk("i_all_served", 32'(i_done), 32'(i_issued));
    chk("d_all_served", 32'(d_done), 32'(d_issued));
    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
